// File: rtl/fd_txn_sequencer.sv
// fd_txn_sequencer: collects one FD transaction, fetches its DRAM entries over the bridge, launches the datapath and writes back dirty entries
module fd_txn_sequencer #(
  parameter int ID_W = 8,
  parameter int DW = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            act_valid,
  input  logic [3:0]      action,
  input  logic            id_valid,
  input  logic [ID_W-1:0] d_id,
  input  logic            cus_valid,
  input  logic [15:0]     ctm_info,
  input  logic            res_valid,
  input  logic [ID_W-1:0] res_id,
  input  logic            food_valid,
  input  logic [5:0]      food_ser,
  output logic            C_in_valid,
  output logic            C_r_wb,
  output logic [ID_W-1:0] C_addr,
  output logic [DW-1:0]   C_data_w,
  input  logic            C_out_valid,
  input  logic [DW-1:0]   C_data_r,
  output logic            ex_valid,
  output logic [3:0]      ex_act,
  output logic [DW/2-1:0] ex_dman,
  output logic [DW/2-1:0] ex_res,
  output logic [15:0]     ex_ctm,
  output logic [5:0]      ex_food,
  output logic [ID_W-1:0] ex_cancel_res,
  input  logic            ex_done,
  input  logic [DW/2-1:0] ex_dman_wr,
  input  logic [DW/2-1:0] ex_res_wr,
  input  logic            ex_dman_dirty,
  input  logic            ex_res_dirty,
  output logic            busy,
  output logic            seq_done
);
  localparam int HW = DW / 2;
  typedef enum logic [3:0] {
    S_IDLE, S_COLLECT, S_RD_D, S_WT_D, S_RD_R, S_WT_R, S_EXEC,
    S_WT_EX, S_WR_D, S_WT_WD, S_WR_R, S_WT_WR, S_DONE
  } state_t;
  state_t r_state, w_next;
  logic [3:0] r_act;
  logic [ID_W-1:0] r_did, r_rid, r_last_did, r_last_rid, r_ed, r_er;
  logic r_did_v, r_rid_v, r_food_v, r_same, r_wr;
  logic [15:0] r_ctm;
  logic [5:0] r_food;
  logic [DW-1:0] r_a, r_b;
  logic [HW-1:0] r_dman_wr, r_res_wr;
  logic w_take, w_deliver, w_order, w_cancel, w_nd, w_nr, w_fin, w_same, w_wd, w_wr, w_exv;
  logic [ID_W-1:0] w_did, w_rid, w_er;
  assign w_take    = r_act == 4'd1;
  assign w_deliver = r_act == 4'd2;
  assign w_order   = r_act == 4'd4;
  assign w_cancel  = r_act == 4'd8;
  assign w_nd      = w_take || w_deliver || w_cancel;
  assign w_nr      = w_take || w_order;
  assign w_did     = id_valid ? d_id : r_did_v ? r_did : r_last_did;
  assign w_rid     = res_valid ? res_id : r_rid_v ? r_rid : r_last_rid;
  assign w_er      = w_take ? ctm_info[13:6] : w_rid;
  assign w_same    = w_take && (w_did == ctm_info[13:6]);
  assign w_fin     = r_state == S_COLLECT &&
                     (w_take ? cus_valid : w_order ? food_valid : w_deliver ? id_valid :
                      w_cancel && id_valid && r_rid_v && r_food_v);
  assign w_wd      = w_nd && (ex_dman_dirty || (r_same && ex_res_dirty));
  assign w_wr      = w_nr && !r_same && ex_res_dirty;
  assign w_exv     = r_state >= S_EXEC;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = act_valid && action != 4'd0 ? S_COLLECT : S_IDLE;
      S_COLLECT: w_next = !w_fin ? S_COLLECT : w_nd ? S_RD_D : S_RD_R;
      S_RD_D:    w_next = S_WT_D;
      S_WT_D:    w_next = !C_out_valid ? S_WT_D : w_nr && !r_same ? S_RD_R : S_EXEC;
      S_RD_R:    w_next = S_WT_R;
      S_WT_R:    w_next = C_out_valid ? S_EXEC : S_WT_R;
      S_EXEC:    w_next = S_WT_EX;
      S_WT_EX:   w_next = !ex_done ? S_WT_EX : w_wd ? S_WR_D : w_wr ? S_WR_R : S_DONE;
      S_WR_D:    w_next = S_WT_WD;
      S_WT_WD:   w_next = !C_out_valid ? S_WT_WD : r_wr ? S_WR_R : S_DONE;
      S_WR_R:    w_next = S_WT_WR;
      S_WT_WR:   w_next = C_out_valid ? S_DONE : S_WT_WR;
      default:   w_next = S_IDLE;
    endcase
  end
  assign C_in_valid    = r_state == S_RD_D || r_state == S_RD_R || r_state == S_WR_D || r_state == S_WR_R;
  assign C_r_wb        = r_state == S_RD_D || r_state == S_RD_R;
  assign C_addr        = (r_state == S_RD_D || r_state == S_WR_D) ? r_ed :
                         (r_state == S_RD_R || r_state == S_WR_R) ? r_er : '0;
  assign C_data_w      = r_state == S_WR_D ? {r_dman_wr, r_same ? r_res_wr : r_a[HW-1:0]} :
                         r_state == S_WR_R ? {r_b[DW-1:HW], r_res_wr} : '0;
  assign ex_valid      = r_state == S_EXEC;
  assign ex_act        = w_exv ? r_act : '0;
  assign ex_dman       = w_exv && w_nd ? r_a[DW-1:HW] : '0;
  assign ex_res        = w_exv && w_nr ? r_b[HW-1:0] : '0;
  assign ex_ctm        = w_exv ? r_ctm : '0;
  assign ex_food       = w_exv ? r_food : '0;
  assign ex_cancel_res = w_exv && w_cancel ? r_rid : '0;
  assign busy          = r_state >= S_RD_D && r_state <= S_WT_WR;
  assign seq_done      = r_state == S_DONE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_act      <= '0;
      r_did      <= '0;
      r_rid      <= '0;
      r_last_did <= '0;
      r_last_rid <= '0;
      r_ed       <= '0;
      r_er       <= '0;
      r_did_v    <= 1'b0;
      r_rid_v    <= 1'b0;
      r_food_v   <= 1'b0;
      r_same     <= 1'b0;
      r_wr       <= 1'b0;
      r_ctm      <= '0;
      r_food     <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_dman_wr  <= '0;
      r_res_wr   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && act_valid && action != 4'd0) begin
        r_act    <= action;
        r_did    <= '0;
        r_rid    <= '0;
        r_ctm    <= '0;
        r_food   <= '0;
        r_did_v  <= 1'b0;
        r_rid_v  <= 1'b0;
        r_food_v <= 1'b0;
      end
      if (r_state == S_COLLECT) begin
        if (id_valid) begin
          r_did   <= d_id;
          r_did_v <= 1'b1;
        end
        if (cus_valid) r_ctm <= ctm_info;
        if (res_valid) begin
          r_rid   <= res_id;
          r_rid_v <= 1'b1;
        end
        if (food_valid) begin
          r_food   <= food_ser;
          r_food_v <= 1'b1;
        end
        if (w_fin) begin
          r_ed   <= w_did;
          r_er   <= w_er;
          r_same <= w_same;
          if (w_nd) r_last_did <= w_did;
          if (w_nr) r_last_rid <= w_er;
        end
      end
      if (r_state == S_WT_D && C_out_valid) begin
        r_a <= C_data_r;
        if (r_same) r_b <= C_data_r;
      end
      if (r_state == S_WT_R && C_out_valid) r_b <= C_data_r;
      if (r_state == S_WT_EX && ex_done) begin
        r_dman_wr <= ex_dman_wr;
        r_res_wr  <= ex_res_wr;
        r_wr      <= w_wr;
      end
    end
  end
endmodule

// File: tb/tb_fd_txn_sequencer.sv
// tb_fd_txn_sequencer: directed bench with bridge and datapath models for fd_txn_sequencer
module tb_fd_txn_sequencer;
  logic clk = 0, rst_n = 0;
  logic act_valid = 0, id_valid = 0, cus_valid = 0, res_valid = 0, food_valid = 0;
  logic [3:0] action = 0;
  logic [7:0] d_id = 0, res_id = 0;
  logic [15:0] ctm_info = 0;
  logic [5:0] food_ser = 0;
  logic C_in_valid, C_r_wb, C_out_valid = 0;
  logic [7:0] C_addr;
  logic [63:0] C_data_w, C_data_r = 0;
  logic ex_valid, ex_done = 0, ex_dman_dirty = 0, ex_res_dirty = 0, busy, seq_done;
  logic [3:0] ex_act;
  logic [31:0] ex_dman, ex_res, ex_dman_wr = 0, ex_res_wr = 0;
  logic [15:0] ex_ctm;
  logic [5:0] ex_food;
  logic [7:0] ex_cancel_res;
  int cyc = 0, n_chk = 0, n_err = 0, t_exd = 0, t_sd = 0;
  logic [72:0] q_req [$];
  logic [63:0] mem [256];
  logic [31:0] t_dwr = 0, t_rwr = 0;
  logic t_dd = 0, t_rd = 0;
  logic [31:0] obs_dman, obs_res;
  logic [7:0] obs_cres;
  logic [3:0] obs_act;
  logic [15:0] obs_ctm;
  logic [5:0] obs_food;
  fd_txn_sequencer dut (
    .clk(clk), .rst_n(rst_n), .act_valid(act_valid), .action(action),
    .id_valid(id_valid), .d_id(d_id), .cus_valid(cus_valid), .ctm_info(ctm_info),
    .res_valid(res_valid), .res_id(res_id), .food_valid(food_valid), .food_ser(food_ser),
    .C_in_valid(C_in_valid), .C_r_wb(C_r_wb), .C_addr(C_addr), .C_data_w(C_data_w),
    .C_out_valid(C_out_valid), .C_data_r(C_data_r),
    .ex_valid(ex_valid), .ex_act(ex_act), .ex_dman(ex_dman), .ex_res(ex_res),
    .ex_ctm(ex_ctm), .ex_food(ex_food), .ex_cancel_res(ex_cancel_res),
    .ex_done(ex_done), .ex_dman_wr(ex_dman_wr), .ex_res_wr(ex_res_wr),
    .ex_dman_dirty(ex_dman_dirty), .ex_res_dirty(ex_res_dirty),
    .busy(busy), .seq_done(seq_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin : bridge
    int lat;
    logic rd;
    logic [7:0] ad;
    lat = 0;
    rd = 0;
    ad = 0;
    forever begin
      @(negedge clk);
      C_out_valid = 0;
      if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          C_out_valid = 1;
          C_data_r = rd ? mem[ad] : 64'h0;
        end
      end
      if (C_in_valid) begin
        q_req.push_back({C_r_wb, C_addr, C_r_wb ? 64'h0 : C_data_w});
        if (!C_r_wb) mem[C_addr] = C_data_w;
        rd = C_r_wb;
        ad = C_addr;
        lat = 2;
      end
    end
  end
  initial begin : dpath
    int exl;
    exl = 0;
    forever begin
      @(negedge clk);
      ex_done = 0;
      if (exl > 0) begin
        exl--;
        if (exl == 0) begin
          ex_done = 1;
          ex_dman_wr = t_dwr;
          ex_res_wr = t_rwr;
          ex_dman_dirty = t_dd;
          ex_res_dirty = t_rd;
          t_exd = cyc;
        end
      end
      if (ex_valid) begin
        obs_dman = ex_dman;
        obs_res = ex_res;
        obs_cres = ex_cancel_res;
        obs_act = ex_act;
        obs_ctm = ex_ctm;
        obs_food = ex_food;
        exl = 3;
      end
    end
  end
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic exp_req(input string tag, input logic rw, input logic [7:0] a, input logic [63:0] d);
    logic [72:0] got;
    got = q_req.size() > 0 ? q_req.pop_front() : '1;
    check(tag, got, {rw, a, d});
  endtask
  task automatic wait_done(input string tag);
    bit seen;
    seen = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (seq_done) begin
        seen = 1;
        t_sd = cyc;
      end
    end
    check({tag, "_done"}, seen, 1);
  endtask
  task automatic set_ex(input logic [31:0] dwr, input logic [31:0] rwr, input logic dd, input logic rdy);
    t_dwr = dwr;
    t_rwr = rwr;
    t_dd = dd;
    t_rd = rdy;
    obs_dman = 32'hDEADBEEF;
    obs_res = 32'hDEADBEEF;
    obs_cres = 8'hEE;
    obs_act = 4'hF;
    obs_ctm = 16'hBEEF;
    obs_food = 6'h3F;
  endtask
  task automatic pulse_act(input logic [3:0] a);
    @(negedge clk);
    action = a;
    act_valid = 1;
    @(negedge clk);
    act_valid = 0;
    action = 0;
  endtask
  task automatic pulse_id(input logic [7:0] v);
    @(negedge clk);
    d_id = v;
    id_valid = 1;
    @(negedge clk);
    id_valid = 0;
  endtask
  task automatic pulse_cus(input logic [15:0] v);
    @(negedge clk);
    ctm_info = v;
    cus_valid = 1;
    @(negedge clk);
    cus_valid = 0;
  endtask
  task automatic pulse_res(input logic [7:0] v);
    @(negedge clk);
    res_id = v;
    res_valid = 1;
    @(negedge clk);
    res_valid = 0;
  endtask
  task automatic pulse_food(input logic [5:0] v);
    @(negedge clk);
    food_ser = v;
    food_valid = 1;
    @(negedge clk);
    food_valid = 0;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 64'h0;
    mem[5]  = 64'h0102_0304_0506_0708;
    mem[9]  = 64'h1112_1314_1516_1718;
    mem[7]  = 64'h2122_2324_2526_2728;
    mem[3]  = 64'h3132_3334_3536_3738;
    mem[12] = 64'h4142_4344_4546_4748;
    mem[20] = 64'h5152_5354_5556_5758;
    mem[6]  = 64'h6162_6364_6566_6768;
    repeat (3) @(negedge clk);
    check("rst_cin", C_in_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", seq_done, 0);
    check("rst_exv", ex_valid, 0);
    rst_n = 1;
    set_ex(32'hD000_0001, 32'hE000_0001, 1, 1);
    pulse_act(4'd1);
    pulse_id(8'd5);
    pulse_cus(16'h0252);
    check("t1_cin_next", C_in_valid, 1);
    check("t1_busy", busy, 1);
    check("t1_addr0", C_addr, 5);
    wait_done("t1");
    exp_req("t1_rd5", 1, 8'd5, 64'h0);
    exp_req("t1_rd9", 1, 8'd9, 64'h0);
    exp_req("t1_wr5", 0, 8'd5, 64'hD000_0001_0506_0708);
    exp_req("t1_wr9", 0, 8'd9, 64'h1112_1314_E000_0001);
    check("t1_nreq", q_req.size(), 0);
    check("t1_dman", obs_dman, 32'h0102_0304);
    check("t1_res", obs_res, 32'h1516_1718);
    check("t1_act", obs_act, 1);
    check("t1_ctm", obs_ctm, 16'h0252);
    set_ex(32'hD000_0002, 32'hE000_0002, 1, 0);
    pulse_act(4'd1);
    pulse_id(8'd7);
    pulse_cus(16'h01E3);
    wait_done("t2");
    exp_req("t2_rd7", 1, 8'd7, 64'h0);
    exp_req("t2_wr7", 0, 8'd7, 64'hD000_0002_E000_0002);
    check("t2_nreq", q_req.size(), 0);
    check("t2_dman", obs_dman, 32'h2122_2324);
    check("t2_res", obs_res, 32'h2526_2728);
    set_ex(32'hD000_0003, 32'hE000_0003, 0, 0);
    pulse_act(4'd2);
    pulse_id(8'd3);
    wait_done("t3");
    exp_req("t3_rd3", 1, 8'd3, 64'h0);
    check("t3_nreq", q_req.size(), 0);
    check("t3_dman", obs_dman, 32'h3132_3334);
    check("t3_res", obs_res, 0);
    check("t3_ctm", obs_ctm, 0);
    check("t3_done_lat", t_sd - t_exd, 1);
    set_ex(32'h0, 32'h0, 0, 0);
    pulse_act(4'd1);
    pulse_id(8'd12);
    pulse_cus(16'h0181);
    wait_done("t4a");
    exp_req("t4a_rd12", 1, 8'd12, 64'h0);
    exp_req("t4a_rd6", 1, 8'd6, 64'h0);
    check("t4a_nreq", q_req.size(), 0);
    set_ex(32'h0, 32'h0, 0, 0);
    pulse_act(4'd1);
    pulse_cus(16'h0240);
    wait_done("t4b");
    exp_req("t4b_rd12", 1, 8'd12, 64'h0);
    exp_req("t4b_rd9", 1, 8'd9, 64'h0);
    check("t4b_nreq", q_req.size(), 0);
    check("t4b_dman", obs_dman, 32'h4142_4344);
    check("t4b_res", obs_res, 32'hE000_0001);
    set_ex(32'hD000_0004, 32'hE000_0003, 1, 1);
    pulse_act(4'd4);
    pulse_food(6'h15);
    wait_done("t4c");
    exp_req("t4c_rd9", 1, 8'd9, 64'h0);
    exp_req("t4c_wr9", 0, 8'd9, 64'h1112_1314_E000_0003);
    check("t4c_nreq", q_req.size(), 0);
    check("t4c_dman", obs_dman, 0);
    check("t4c_res", obs_res, 32'hE000_0001);
    check("t4c_food", obs_food, 6'h15);
    set_ex(32'hD000_0005, 32'hE000_0005, 0, 1);
    pulse_act(4'd8);
    pulse_res(8'd4);
    pulse_food(6'h21);
    pulse_id(8'd20);
    wait_done("t5");
    exp_req("t5_rd20", 1, 8'd20, 64'h0);
    check("t5_nreq", q_req.size(), 0);
    check("t5_dman", obs_dman, 32'h5152_5354);
    check("t5_res", obs_res, 0);
    check("t5_cres", obs_cres, 4);
    set_ex(32'h0, 32'h0, 0, 0);
    pulse_act(4'd2);
    pulse_id(8'd5);
    check("t6_cin", C_in_valid, 1);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check("t6_rst_cin", C_in_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_addr", C_addr, 0);
    check("t6_rst_exv", ex_valid, 0);
    check("t6_rst_done", seq_done, 0);
    repeat (6) @(negedge clk);
    exp_req("t6_rd5", 1, 8'd5, 64'h0);
    check("t6_quiet_nreq", q_req.size(), 0);
    check("t6_quiet_busy", busy, 0);
    pulse_act(4'd1);
    pulse_cus(16'h00C0);
    wait_done("t7");
    exp_req("t7_rd0", 1, 8'd0, 64'h0);
    exp_req("t7_rd3", 1, 8'd3, 64'h0);
    check("t7_nreq", q_req.size(), 0);
    check("t7_dman", obs_dman, 0);
    check("t7_res", obs_res, 32'h3536_3738);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fd_txn_sequencer.md
Name: fd_txn_sequencer

Overview:
- Transaction sequencer for the food-delivery (FD) engine.
- Collects one multi-cycle input transaction (action, delivery-man ID, customer info, restaurant ID, food/servings) and fetches the required 64-bit DRAM entries through the bridge.
- Hands the delivery-man and restaurant records to the action datapath, then writes back only the dirty entries.
- Sits between the pattern-side input bus, the bridge and the FD execution datapath.

Parameters:
- ID_W, 8, width of delivery-man and restaurant IDs and of the bridge entry address
- DW, 64, DRAM entry width: [63:32] delivery-man info (two 16-bit customer records), [31:0] restaurant info (limit, FOOD1, FOOD2, FOOD3)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- act_valid  in  1  action strobe; starts a transaction
- action  in  4  0 none, 1 Take, 2 Deliver, 4 Order, 8 Cancel
- id_valid  in  1  delivery-man ID strobe
- d_id  in  8  delivery-man ID
- cus_valid  in  1  customer-info strobe
- ctm_info  in  16  {status[15:14], res_ID[13:6], food_ID[5:4], servings[3:0]}
- res_valid  in  1  restaurant ID strobe
- res_id  in  8  restaurant ID
- food_valid  in  1  food strobe
- food_ser  in  6  {food_ID[5:4], servings[3:0]}
- C_in_valid  out  1  bridge request pulse
- C_r_wb  out  1  1 = read, 0 = write
- C_addr  out  8  entry index
- C_data_w  out  64  write data
- C_out_valid  in  1  bridge completion pulse; read data valid this cycle
- C_data_r  in  64  read data
- ex_valid  out  1  one-cycle launch pulse to the datapath
- ex_act  out  4  latched action
- ex_dman  out  32  delivery-man record
- ex_res  out  32  restaurant record
- ex_ctm  out  16  latched customer info
- ex_food  out  6  latched food/servings
- ex_cancel_res  out  8  latched restaurant ID for a Cancel
- ex_done  in  1  datapath completion pulse
- ex_dman_wr  in  32  updated delivery-man record
- ex_res_wr  in  32  updated restaurant record
- ex_dman_dirty  in  1  delivery-man record modified
- ex_res_dirty  in  1  restaurant record modified
- busy  out  1  high from the completing strobe+1 until seq_done
- seq_done  out  1  one-cycle pulse when the transaction is fully retired

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE; all outputs 0.
  - last_did and last_rid are cleared to 0; all latched fields are cleared.
  - Reset mid-transaction aborts it with no further bridge requests. An in-flight bridge completion arriving afterwards is ignored.
- FSM states: IDLE, COLLECT, RD_D, WT_D, RD_R, WT_R, EXEC, WT_EX, WR_D, WT_WD, WR_R, WT_WR, DONE.
- IDLE -> COLLECT on act_valid with a nonzero action. act_valid with action 0 is ignored.
- COLLECT: each strobe latches its field. The transaction completes on:
  - Take: cus_valid. Uses the latched d_id if id_valid arrived earlier, else last_did.
  - Deliver: id_valid.
  - Order: food_valid. Uses the latched res_id if res_valid arrived earlier, else last_rid.
  - Cancel: id_valid, after res_valid and food_valid.
- Strobes in IDLE (other than act_valid) or after completion are ignored.
- On completion:
  - last_did is updated for Take, Deliver and Cancel.
  - last_rid is updated for Order, and for Take using ctm_info.res_ID.
- Entry selection:
  - e_d = delivery-man ID (Take, Deliver, Cancel).
  - e_r = restaurant ID (Take: ctm_info.res_ID; Order: resolved res_id).
  - same = Take and e_d == e_r.
- Reads:
  - Take: read e_d; read e_r unless same.
  - Deliver and Cancel: read e_d only.
  - Order: read e_r only.
- Bridge handshake:
  - C_in_valid is high exactly one cycle, with C_addr, C_r_wb and C_data_w stable that cycle.
  - Only one request is outstanding. The next request is issued no earlier than the cycle after C_out_valid.
  - C_in_valid rises the cycle after the completing strobe.
  - A read's word is captured on C_out_valid (word A for e_d, word B for e_r). If same, B = A.
- EXEC:
  - ex_valid pulses one cycle after the last read completes.
  - ex_dman = A[63:32] and ex_res = B[31:0]; ex_* data outputs hold until seq_done.
  - Unused records output 0.
- WT_EX: waits indefinitely for ex_done. ex_done in any other state is ignored.
- Writeback:
  - If same: one write to e_d of {ex_dman_wr, ex_res_wr}, only if either dirty flag is set.
  - Otherwise: write {ex_dman_wr, A[31:0]} to e_d if ex_dman_dirty; then write {B[63:32], ex_res_wr} to e_r if ex_res_dirty.
  - A dirty flag for a record that was not fetched is ignored.
  - No dirty flags set means no writes.
- DONE: seq_done pulses the cycle after the last write's C_out_valid, or the cycle after ex_done if there are no writes. Returns to IDLE; busy drops with seq_done.
- Back-to-back: act_valid in the same cycle as seq_done is ignored. It is accepted from the following cycle.

Test Plan:
- Reset then Take with id_valid d_id=5 and ctm_info res_ID=9 -> reads addr 5 then 9. ex_dman=A[63:32], ex_res=B[31:0]. With both dirty, writes addr 5 {dman_wr, A[31:0]} then addr 9 {B[63:32], res_wr}, then seq_done.
- Take d_id=7, res_ID=7 -> single read of addr 7. With dirty=1/0, single write {dman_wr, res_wr} to 7.
- Deliver d_id=3 with both dirty flags 0 -> one read of addr 3, no writes, seq_done one cycle after ex_done.
- Take d_id=12, then Take with no id_valid, then Order with no res_valid -> second Take reads addr 12; Order reads the second Take's res_ID.
- Cancel: res_valid 4, food_valid, id_valid 20 -> reads addr 20 only; ex_cancel_res=4; res dirty ignored.
- rst_n low during WT_D -> all outputs 0 next cycle. A late C_out_valid causes no activity; the next transaction runs normally with last_did=0.
